// File: rtl/asteroids_pkg.sv
// Shared entity layout and collision-scheduler state encoding for the asteroids game.
package asteroids_pkg;

  localparam int unsigned ENTITY_SIZE = 34;
  localparam int unsigned ACTIVE_BIT  = 33;
  localparam int unsigned X_LSB       = 6;
  localparam int unsigned Y_LSB       = 16;
  localparam int unsigned COORD_W     = 10;

  typedef logic [ENTITY_SIZE-1:0] entity_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHOT,
    ST_SHIP,
    ST_SETTLE
  } coll_state_t;

  function automatic logic [COORD_W-1:0] ent_x(input entity_t e);
    return e[X_LSB +: COORD_W];
  endfunction

  function automatic logic [COORD_W-1:0] ent_y(input entity_t e);
    return e[Y_LSB +: COORD_W];
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational axis-aligned box test between two active entities; HALF_SUM is the
// summed half-extent of the pair. Coordinates are unsigned with no screen wrap.
module box_overlap
  import asteroids_pkg::*;
#(
  parameter int unsigned HALF_SUM = 9
) (
  input  entity_t a_i,
  input  entity_t b_i,
  output logic    hit_o
);

  localparam int unsigned DW = COORD_W + 1;
  localparam logic [DW-1:0] LIMIT = DW'(HALF_SUM);

  logic signed [DW-1:0] dx;
  logic signed [DW-1:0] dy;
  logic        [DW-1:0] adx;
  logic        [DW-1:0] ady;
  logic                 unused_fields;

  always_comb begin
    dx    = $signed({1'b0, ent_x(a_i)}) - $signed({1'b0, ent_x(b_i)});
    dy    = $signed({1'b0, ent_y(a_i)}) - $signed({1'b0, ent_y(b_i)});
    adx   = dx[DW-1] ? -dx : dx;
    ady   = dy[DW-1] ? -dy : dy;
    hit_o = a_i[ACTIVE_BIT] & b_i[ACTIVE_BIT] & (adx <= LIMIT) & (ady <= LIMIT);
  end

  // Direction and spare bits carry no collision information.
  assign unused_fields = ^{a_i[X_LSB-1:0], a_i[ACTIVE_BIT-1:Y_LSB+COORD_W],
                           b_i[X_LSB-1:0], b_i[ACTIVE_BIT-1:Y_LSB+COORD_W]};

endmodule

// File: rtl/collision_scheduler.sv
// Scans one shot per cycle against all asteroids, then the ship, pulsing deletes and
// keeping a saturating score. Ship pass present only when SHIP_COLLISION_EN is defined.
module collision_scheduler
  import asteroids_pkg::entity_t, asteroids_pkg::coll_state_t,
         asteroids_pkg::ST_IDLE, asteroids_pkg::ST_SHOT,
         asteroids_pkg::ST_SHIP, asteroids_pkg::ST_SETTLE;
#(
  parameter int unsigned ENTITY_SIZE   = 34,
  parameter int unsigned MAX_SHOTS     = 3,
  parameter int unsigned MAX_ASTEROIDS = 4,
  parameter int unsigned AST_HALF      = 8,
  parameter int unsigned SHOT_HALF     = 1,
  parameter int unsigned SHIP_HALF     = 4
) (
  input  logic                                 move_clk,
  input  logic                                 reset_n,
  input  logic                                 en,
  input  logic [ENTITY_SIZE-1:0]               ship,
  input  logic [MAX_SHOTS*ENTITY_SIZE-1:0]     shots,
  input  logic [MAX_ASTEROIDS*ENTITY_SIZE-1:0] asteroids,
  output logic                                 delete_shot,
  output logic [$clog2(MAX_SHOTS)-1:0]         shot_address,
  output logic                                 delete_asteroid,
  output logic [$clog2(MAX_ASTEROIDS)-1:0]     asteroid_address,
  output logic                                 ship_hit,
  output logic [15:0]                          score,
  output logic                                 busy,
  output logic                                 scan_done
);

  localparam int unsigned SA_W = $clog2(MAX_SHOTS);
  localparam int unsigned AA_W = $clog2(MAX_ASTEROIDS);
  localparam logic [SA_W-1:0] LAST_SHOT = SA_W'(MAX_SHOTS - 1);

  coll_state_t              state_q, state_d;
  logic [SA_W-1:0]          idx_q, idx_d;
  logic [MAX_SHOTS-1:0]     killed_s_q, killed_s_d;
  logic [MAX_ASTEROIDS-1:0] killed_a_q, killed_a_d;
  logic [15:0]              score_q, score_d;
  logic                     del_shot_q, del_shot_d;
  logic [SA_W-1:0]          shot_addr_q, shot_addr_d;
  logic                     del_ast_q, del_ast_d;
  logic [AA_W-1:0]          ast_addr_q, ast_addr_d;
  logic                     ship_hit_q, ship_hit_d;
  logic                     scan_done_q, scan_done_d;

  entity_t                  shot_arr [MAX_SHOTS];
  entity_t                  cur_shot;
  logic [MAX_ASTEROIDS-1:0] shot_ov;
  logic [MAX_ASTEROIDS-1:0] shot_cand;
  logic [AA_W-1:0]          shot_sel;
  logic                     shot_fire;

  for (genvar i = 0; i < MAX_SHOTS; i++) begin : g_shot
    assign shot_arr[i] = shots[i*ENTITY_SIZE +: ENTITY_SIZE];
  end

  assign cur_shot = shot_arr[idx_q];

`ifdef SHIP_COLLISION_EN
  logic [MAX_ASTEROIDS-1:0] ship_ov;
  logic [MAX_ASTEROIDS-1:0] ship_cand;
  logic [AA_W-1:0]          ship_sel;
`else
  logic                     unused_ship;
  assign unused_ship = ^ship;
`endif

  for (genvar k = 0; k < MAX_ASTEROIDS; k++) begin : g_ast
    entity_t ast;
    assign ast = asteroids[k*ENTITY_SIZE +: ENTITY_SIZE];

    box_overlap #(
      .HALF_SUM(AST_HALF + SHOT_HALF)
    ) u_shot_ov (
      .a_i  (cur_shot),
      .b_i  (ast),
      .hit_o(shot_ov[k])
    );

`ifdef SHIP_COLLISION_EN
    box_overlap #(
      .HALF_SUM(AST_HALF + SHIP_HALF)
    ) u_ship_ov (
      .a_i  (ship),
      .b_i  (ast),
      .hit_o(ship_ov[k])
    );
`endif
  end

  // Slots already hit this scan are masked so the controllers can clear them at leisure.
  assign shot_cand = shot_ov & ~killed_a_q;
  assign shot_fire = ~killed_s_q[idx_q] & (|shot_cand);

  always_comb begin
    shot_sel = '0;
    for (int unsigned k = 0; k < MAX_ASTEROIDS; k++) begin
      if (shot_cand[MAX_ASTEROIDS-1-k]) shot_sel = AA_W'(MAX_ASTEROIDS - 1 - k);
    end
  end

`ifdef SHIP_COLLISION_EN
  assign ship_cand = ship_ov & ~killed_a_q;

  always_comb begin
    ship_sel = '0;
    for (int unsigned k = 0; k < MAX_ASTEROIDS; k++) begin
      if (ship_cand[MAX_ASTEROIDS-1-k]) ship_sel = AA_W'(MAX_ASTEROIDS - 1 - k);
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    killed_s_d  = killed_s_q;
    killed_a_d  = killed_a_q;
    score_d     = score_q;
    del_shot_d  = 1'b0;
    shot_addr_d = shot_addr_q;
    del_ast_d   = 1'b0;
    ast_addr_d  = ast_addr_q;
    ship_hit_d  = 1'b0;
    scan_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en) begin
          idx_d   = '0;
          state_d = ST_SHOT;
        end
      end

      ST_SHOT: begin
        if (shot_fire) begin
          del_shot_d           = 1'b1;
          shot_addr_d          = idx_q;
          del_ast_d            = 1'b1;
          ast_addr_d           = shot_sel;
          killed_s_d[idx_q]    = 1'b1;
          killed_a_d[shot_sel] = 1'b1;
          if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        end
        if (idx_q == LAST_SHOT) begin
`ifdef SHIP_COLLISION_EN
          state_d = ST_SHIP;
`else
          state_d = ST_SETTLE;
`endif
        end else begin
          idx_d = idx_q + SA_W'(1);
        end
      end

`ifdef SHIP_COLLISION_EN
      ST_SHIP: begin
        if (|ship_cand) begin
          ship_hit_d           = 1'b1;
          del_ast_d            = 1'b1;
          ast_addr_d           = ship_sel;
          killed_a_d[ship_sel] = 1'b1;
        end
        state_d = ST_SETTLE;
      end
`endif

      ST_SETTLE: begin
        killed_s_d  = '0;
        killed_a_d  = '0;
        scan_done_d = 1'b1;
        state_d     = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge move_clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      killed_s_q  <= '0;
      killed_a_q  <= '0;
      score_q     <= '0;
      del_shot_q  <= 1'b0;
      shot_addr_q <= '0;
      del_ast_q   <= 1'b0;
      ast_addr_q  <= '0;
      ship_hit_q  <= 1'b0;
      scan_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      killed_s_q  <= killed_s_d;
      killed_a_q  <= killed_a_d;
      score_q     <= score_d;
      del_shot_q  <= del_shot_d;
      shot_addr_q <= shot_addr_d;
      del_ast_q   <= del_ast_d;
      ast_addr_q  <= ast_addr_d;
      ship_hit_q  <= ship_hit_d;
      scan_done_q <= scan_done_d;
    end
  end

  assign delete_shot      = del_shot_q;
  assign shot_address     = shot_addr_q;
  assign delete_asteroid  = del_ast_q;
  assign asteroid_address = ast_addr_q;
  assign ship_hit         = ship_hit_q;
  assign score            = score_q;
  assign busy             = (state_q != ST_IDLE);
  assign scan_done        = scan_done_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: a behavioural scan model queues per-cycle
// expected outputs; a second wide instance drives the score into saturation.
module tb_collision_scheduler;

  localparam int SAT_N = 64;
`ifdef SHIP_COLLISION_EN
  localparam int SCAN_LEN = 6;
  localparam int SAT_LEN  = SAT_N + 3;
  localparam logic EXP_SHIP = 1'b1;
`else
  localparam int SCAN_LEN = 5;
  localparam int SAT_LEN  = SAT_N + 2;
  localparam logic EXP_SHIP = 1'b0;
`endif

  logic         move_clk = 1'b0;
  logic         reset_n  = 1'b0;
  logic         en       = 1'b0;
  logic [33:0]  ship     = '0;
  logic [101:0] shots    = '0;
  logic [135:0] asteroids = '0;
  logic         delete_shot, delete_asteroid, ship_hit, busy, scan_done;
  logic [1:0]   shot_address, asteroid_address;
  logic [15:0]  score;

  logic                  en_s = 1'b0;
  logic [33:0]           ship_s = '0;
  logic [SAT_N*34-1:0]   shots_s = '0;
  logic [SAT_N*34-1:0]   asteroids_s = '0;
  logic                  delete_shot_s, delete_asteroid_s, ship_hit_s, busy_s, scan_done_s;
  logic [5:0]            shot_address_s, asteroid_address_s;
  logic [15:0]           score_s;

  int checks = 0;
  int errors = 0;

  always #5 move_clk = ~move_clk;

  collision_scheduler dut (
    .move_clk(move_clk), .reset_n(reset_n), .en(en), .ship(ship), .shots(shots),
    .asteroids(asteroids), .delete_shot(delete_shot), .shot_address(shot_address),
    .delete_asteroid(delete_asteroid), .asteroid_address(asteroid_address),
    .ship_hit(ship_hit), .score(score), .busy(busy), .scan_done(scan_done)
  );

  collision_scheduler #(
    .ENTITY_SIZE(34), .MAX_SHOTS(SAT_N), .MAX_ASTEROIDS(SAT_N),
    .AST_HALF(8), .SHOT_HALF(1), .SHIP_HALF(4)
  ) dut_sat (
    .move_clk(move_clk), .reset_n(reset_n), .en(en_s), .ship(ship_s), .shots(shots_s),
    .asteroids(asteroids_s), .delete_shot(delete_shot_s), .shot_address(shot_address_s),
    .delete_asteroid(delete_asteroid_s), .asteroid_address(asteroid_address_s),
    .ship_hit(ship_hit_s), .score(score_s), .busy(busy_s), .scan_done(scan_done_s)
  );

  typedef struct packed {
    logic        ds;
    logic [1:0]  sa;
    logic        da;
    logic [1:0]  aa;
    logic        sh;
    logic [15:0] sc;
    logic        sd;
    logic        bz;
  } obs_t;

  obs_t exp_q[$];

  int   sx[3], sy[3], ax[4], ay[4];
  bit   sact[3], aact[4];
  int   shipx, shipy;
  bit   shipact;
  int   m_score;
  logic [1:0] m_sa, m_aa;

  function automatic logic [33:0] mk(input bit act, input int x, input int y);
    logic [33:0] e;
    e        = '0;
    e[33]    = act;
    e[25:16] = y[9:0];
    e[15:6]  = x[9:0];
    e[5:0]   = 6'h2B;
    return e;
  endfunction

  function automatic bit ovl(input int x1, input int y1, input int x2, input int y2, input int h);
    return (x1 - x2 <= h) && (x2 - x1 <= h) && (y1 - y2 <= h) && (y2 - y1 <= h);
  endfunction

  function automatic obs_t base();
    obs_t e;
    e    = '0;
    e.sa = m_sa;
    e.aa = m_aa;
    e.sc = 16'(m_score);
    e.bz = 1'b1;
    return e;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ds = delete_shot;  o.sa = shot_address;  o.da = delete_asteroid;
    o.aa = asteroid_address;  o.sh = ship_hit;  o.sc = score;
    o.sd = scan_done;  o.bz = busy;
    return o;
  endfunction

  task automatic step();
    @(posedge move_clk);
    #1;
  endtask

  task automatic clear_all();
    for (int i = 0; i < 3; i++) begin sx[i] = 0; sy[i] = 0; sact[i] = 0; end
    for (int k = 0; k < 4; k++) begin ax[k] = 0; ay[k] = 0; aact[k] = 0; end
    shipx = 0; shipy = 0; shipact = 0;
  endtask

  task automatic apply();
    for (int i = 0; i < 3; i++) shots[i*34 +: 34] = mk(sact[i], sx[i], sy[i]);
    for (int k = 0; k < 4; k++) asteroids[k*34 +: 34] = mk(aact[k], ax[k], ay[k]);
    ship = mk(shipact, shipx, shipy);
  endtask

  // Expected outputs for cycles 1..SCAN_LEN after en is taken in IDLE.
  task automatic model_scan();
    bit   ks[3];
    bit   ka[4];
    bit   found;
    obs_t e;
    for (int i = 0; i < 3; i++) ks[i] = 0;
    for (int k = 0; k < 4; k++) ka[k] = 0;
    exp_q.push_back(base());
    for (int i = 0; i < 3; i++) begin
      found = 0;
      if (sact[i] && !ks[i]) begin
        for (int k = 0; k < 4; k++) begin
          if (!found && aact[k] && !ka[k] && ovl(sx[i], sy[i], ax[k], ay[k], 9)) begin
            found = 1; ks[i] = 1; ka[k] = 1;
            m_sa = 2'(i); m_aa = 2'(k);
            if (m_score < 65535) m_score++;
          end
        end
      end
      e = base();
      e.ds = found;
      e.da = found;
      exp_q.push_back(e);
    end
`ifdef SHIP_COLLISION_EN
    found = 0;
    if (shipact) begin
      for (int k = 0; k < 4; k++) begin
        if (!found && aact[k] && !ka[k] && ovl(shipx, shipy, ax[k], ay[k], 12)) begin
          found = 1; ka[k] = 1; m_aa = 2'(k);
        end
      end
    end
    e = base();
    e.sh = found;
    e.da = found;
    exp_q.push_back(e);
`endif
    e = base();
    e.sd = 1'b1;
    e.bz = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic start_scan();
    en = 1'b1;
    step();
    en = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step();
    step();
    checks++; if (delete_shot !== 1'b0) begin errors++; $display("FAIL reset_delete_shot got %b exp 0", delete_shot); end
    checks++; if (shot_address !== 2'd0) begin errors++; $display("FAIL reset_shot_address got %0d exp 0", shot_address); end
    checks++; if (delete_asteroid !== 1'b0) begin errors++; $display("FAIL reset_delete_asteroid got %b exp 0", delete_asteroid); end
    checks++; if (asteroid_address !== 2'd0) begin errors++; $display("FAIL reset_asteroid_address got %0d exp 0", asteroid_address); end
    checks++; if (ship_hit !== 1'b0) begin errors++; $display("FAIL reset_ship_hit got %b exp 0", ship_hit); end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL reset_score got %h exp 0", score); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (scan_done !== 1'b0) begin errors++; $display("FAIL reset_scan_done got %b exp 0", scan_done); end
    reset_n = 1'b1;
    m_score = 0; m_sa = '0; m_aa = '0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_without_en busy got %b exp 0", busy); end
  endtask

  task automatic test_single_hit();
    obs_t o, e, o2;
    int   cyc;
    clear_all();
    sact[0] = 1; sx[0] = 100; sy[0] = 100;
    aact[2] = 1; ax[2] = 106; ay[2] = 95;
    apply();
    start_scan();
    model_scan();
    cyc = 1; o2 = '0;
    while (exp_q.size() > 0) begin
      o = sample(); e = exp_q.pop_front();
      if (cyc == 2) o2 = o;
      checks++; if (o !== e) begin errors++; $display("FAIL single_hit cycle %0d got %h exp %h", cyc, o, e); end
      if (exp_q.size() > 0) begin step(); cyc++; end
    end
    checks++;
    if (o2.ds !== 1'b1 || o2.sa !== 2'd0 || o2.da !== 1'b1 || o2.aa !== 2'd2) begin
      errors++; $display("FAIL single_hit_pair got ds%b sa%0d da%b aa%0d exp ds1 sa0 da1 aa2", o2.ds, o2.sa, o2.da, o2.aa);
    end
    checks++; if (score !== 16'd1) begin errors++; $display("FAIL single_hit_score got %0d exp 1", score); end
  endtask

  task automatic test_miss();
    obs_t o, e;
    int   cyc, n_del;
    clear_all();
    sact[1] = 1; sx[1] = 100; sy[1] = 100;
    aact[0] = 1; ax[0] = 110; ay[0] = 100;
    apply();
    start_scan();
    model_scan();
    cyc = 1; n_del = 0;
    while (exp_q.size() > 0) begin
      o = sample(); e = exp_q.pop_front();
      n_del += o.ds + o.da;
      checks++; if (o !== e) begin errors++; $display("FAIL miss cycle %0d got %h exp %h", cyc, o, e); end
      if (exp_q.size() > 0) begin step(); cyc++; end
    end
    checks++; if (n_del !== 0) begin errors++; $display("FAIL miss_deletes got %0d exp 0", n_del); end
    checks++; if (score !== 16'd1) begin errors++; $display("FAIL miss_score got %0d exp 1", score); end
  endtask

  task automatic test_two_shots();
    obs_t o, e;
    int   cyc, n_ds, n_da;
    clear_all();
    sact[0] = 1; sx[0] = 200; sy[0] = 300;
    sact[1] = 1; sx[1] = 202; sy[1] = 301;
    aact[1] = 1; ax[1] = 205; ay[1] = 300;
    apply();
    start_scan();
    model_scan();
    cyc = 1; n_ds = 0; n_da = 0;
    while (exp_q.size() > 0) begin
      o = sample(); e = exp_q.pop_front();
      n_ds += o.ds; n_da += o.da;
      if (o.ds && o.sa !== 2'd0) begin
        checks++; errors++; $display("FAIL two_shots_addr got %0d exp 0", o.sa);
      end
      checks++; if (o !== e) begin errors++; $display("FAIL two_shots cycle %0d got %h exp %h", cyc, o, e); end
      if (exp_q.size() > 0) begin step(); cyc++; end
    end
    checks++; if (n_ds !== 1 || n_da !== 1) begin errors++; $display("FAIL two_shots_pairs got %0d/%0d exp 1/1", n_ds, n_da); end
    checks++; if (score !== 16'd2) begin errors++; $display("FAIL two_shots_score got %0d exp 2", score); end
  endtask

  task automatic test_ship();
    obs_t o, e;
    int   cyc, n_sh, sd_cyc;
    clear_all();
    shipact = 1; shipx = 50; shipy = 50;
    aact[3] = 1; ax[3] = 60; ay[3] = 50;
    apply();
    start_scan();
    model_scan();
    cyc = 1; n_sh = 0; sd_cyc = 0;
    while (exp_q.size() > 0) begin
      o = sample(); e = exp_q.pop_front();
      n_sh += o.sh;
      if (o.sd) sd_cyc = cyc;
      if (o.sh && (o.da !== 1'b1 || o.aa !== 2'd3)) begin
        checks++; errors++; $display("FAIL ship_delete got da%b aa%0d exp da1 aa3", o.da, o.aa);
      end
      checks++; if (o !== e) begin errors++; $display("FAIL ship cycle %0d got %h exp %h", cyc, o, e); end
      if (exp_q.size() > 0) begin step(); cyc++; end
    end
    checks++; if (n_sh !== int'(EXP_SHIP)) begin errors++; $display("FAIL ship_hit_count got %0d exp %0d", n_sh, EXP_SHIP); end
    checks++; if (sd_cyc !== SCAN_LEN) begin errors++; $display("FAIL ship_scan_len got %0d exp %0d", sd_cyc, SCAN_LEN); end
    checks++; if (score !== 16'd2) begin errors++; $display("FAIL ship_score got %0d exp 2", score); end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    int   cyc, sd1, sd2;
    clear_all();
    sact[0] = 1; sx[0] = 100; sy[0] = 100;
    aact[2] = 1; ax[2] = 106; ay[2] = 95;
    apply();
    en = 1'b1;
    step();
    model_scan();
    model_scan();
    cyc = 1; sd1 = 0; sd2 = 0;
    while (exp_q.size() > 0) begin
      o = sample(); e = exp_q.pop_front();
      if (o.sd) begin if (sd1 == 0) sd1 = cyc; else sd2 = cyc; end
      checks++; if (o !== e) begin errors++; $display("FAIL back_to_back cycle %0d got %h exp %h", cyc, o, e); end
      if (cyc == SCAN_LEN + 1) en = 1'b0;
      if (exp_q.size() > 0) begin step(); cyc++; end
    end
    checks++; if (sd2 - sd1 !== SCAN_LEN) begin errors++; $display("FAIL back_to_back_period got %0d exp %0d", sd2 - sd1, SCAN_LEN); end
    checks++; if (score !== 16'd4) begin errors++; $display("FAIL back_to_back_score got %0d exp 4", score); end
  endtask

  task automatic test_saturation_and_reset();
    int n_done, cyc;
    for (int i = 0; i < SAT_N; i++) begin
      shots_s[i*34 +: 34]     = mk(1'b1, 400, 200);
      asteroids_s[i*34 +: 34] = mk(1'b1, 403, 198);
    end
    n_done = 0; cyc = 0;
    en_s = 1'b1;
    while (n_done < 1025 && cyc < 1025 * SAT_LEN + 100) begin
      step();
      cyc++;
      if (scan_done_s) begin
        n_done++;
        if (n_done == 1023) begin
          checks++; if (score_s !== 16'd65472) begin errors++; $display("FAIL sat_count got %0d exp 65472", score_s); end
        end
        if (n_done == 1024) begin
          checks++; if (score_s !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h exp ffff", score_s); end
        end
        if (n_done == 1025) begin
          checks++; if (score_s !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", score_s); end
          en_s = 1'b0;
        end
      end
    end
    if (n_done < 1025) begin
      checks++; errors++; $display("FAIL sat_timeout got %0d scans exp 1025", n_done);
      en_s = 1'b0;
      step(); step();
    end
    step();
    en_s = 1'b1;
    step();
    en_s = 1'b0;
    step();
    checks++;
    if (delete_shot_s !== 1'b1 || shot_address_s !== 6'd0 || busy_s !== 1'b1) begin
      errors++; $display("FAIL pre_reset_pulse got ds%b sa%0d busy%b exp ds1 sa0 busy1", delete_shot_s, shot_address_s, busy_s);
    end
    reset_n = 1'b0;
    step();
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b exp 0", busy_s); end
    checks++; if (score_s !== 16'd0) begin errors++; $display("FAIL midreset_score got %h exp 0", score_s); end
    checks++;
    if (delete_shot_s !== 1'b0 || delete_asteroid_s !== 1'b0 || ship_hit_s !== 1'b0 || scan_done_s !== 1'b0) begin
      errors++; $display("FAIL midreset_pulses got %b%b%b%b exp 0000", delete_shot_s, delete_asteroid_s, ship_hit_s, scan_done_s);
    end
    checks++;
    if (shot_address_s !== 6'd0 || asteroid_address_s !== 6'd0) begin
      errors++; $display("FAIL midreset_addr got %0d/%0d exp 0/0", shot_address_s, asteroid_address_s);
    end
    checks++; if (score !== 16'd0) begin errors++; $display("FAIL midreset_main_score got %0d exp 0", score); end
    reset_n = 1'b1;
    step();
    step();
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", busy_s); end
  endtask

  initial begin
    clear_all();
    apply();
    test_reset();
    test_single_hit();
    test_miss();
    test_two_shots();
    test_ship();
    test_back_to_back();
    test_saturation_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
